data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of TX FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port daddr, input, 32, meaning the byte address from the CPU data port.
REQ-006 SHALL have port dwdata, input, 32, meaning write data, already lane-replicated by the CPU.
REQ-007 SHALL have port dwe, input, 4, meaning byte-lane write enables, where bit n selects dwdata[8n+7:8n].
REQ-008 SHALL have port drdata, output, 32, meaning read data returned to the CPU.
REQ-009 SHALL have port led, output, 8, meaning the LED register.
REQ-010 SHALL have port tx_data, output, 8, meaning the FIFO head byte.
REQ-011 SHALL have port tx_valid, output, 1, meaning the FIFO is non-empty.
REQ-012 SHALL have port tx_ready, input, 1, meaning the consumer accepts tx_data this cycle.

Function
REQ-013 SHALL decode RAM when daddr < 4*RAM_WORDS, with word index daddr[log2(4*RAM_WORDS)-1:2].
REQ-014 SHALL decode MMIO on word address daddr[31:2], ignoring daddr[1:0], as follows:
- 0x8000_0000 CYCLE: read-only.
- 0x8000_0004 LED: read/write, lane 0 only.
- 0x8000_0008 TXDATA: write-only; reads return 0.
- 0x8000_000C TXSTAT: read and write-1-to-clear.
REQ-015 SHALL drive drdata combinationally, in the same cycle, from daddr, so that a single-cycle CPU completes a load within one clock.
REQ-016 SHALL return 0 on drdata for unmapped reads and SHALL ignore unmapped writes.
REQ-017 SHALL update RAM on the clock edge, writing only the lanes whose dwe bit is 1 and leaving the other lanes unchanged.
REQ-018 SHALL return the pre-edge RAM contents on a RAM read in the same cycle as a write to the same word (no write-through).
REQ-019 SHALL implement CYCLE as a 32-bit counter that increments by 1 every non-reset cycle, wraps from 0xFFFF_FFFF to 0, and ignores writes.
REQ-020 SHALL return the current CYCLE register value on a CYCLE read.
REQ-021 SHALL load led from dwdata[7:0] when LED is written with dwe[0]=1, and SHALL return {24'b0, led} on an LED read.
REQ-022 SHALL treat a write to TXDATA with dwe[0]=1 as a push of dwdata[7:0].
REQ-023 SHALL occur a pop when tx_valid and tx_ready are both 1; the head then advances at the edge.
REQ-024 SHALL return {29'b0, overflow, full, empty} on a TXSTAT read, where full means count==FIFO_DEPTH and empty means count==0.
REQ-025 SHALL accept a push if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
REQ-026 SHALL drop any push that is not accepted, set the sticky overflow flag, and leave the FIFO unchanged.
REQ-027 SHALL, on a simultaneous push and pop, leave count unchanged and keep FIFO order intact.
REQ-028 SHALL set tx_valid low when count==0; tx_data is then don't-care.
REQ-029 SHALL keep tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-030 SHALL clear overflow on a TXSTAT write with dwe[0]=1 and dwdata[2]=1.
REQ-031 SHALL keep overflow set when a set and a clear occur in the same cycle (set wins).
REQ-032 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-033 SHALL hold count in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-034 SHALL, while reset=1 at the edge, set CYCLE=0, led=0, count=0, both pointers to 0 and overflow=0; tx_valid is therefore 0 in the following cycle.
REQ-035 SHALL ignore pushes, pops and writes in any cycle where reset=1.
REQ-036 SHALL not clear RAM contents on reset.
REQ-037 SHALL flush the FIFO on reset mid-transfer, discarding all pending bytes.

Verification
REQ-038 SHALL cover byte lanes: SW 0x1122_3344 to 0x10, then dwe=0010 with dwdata=0xAAAA_AAAA -> drdata at 0x10 reads 0x1122_AA44.
REQ-039 SHALL cover the counter: 5 cycles after reset release, a read of 0x8000_0000 -> returns 5; force the counter to 0xFFFF_FFFF -> reads 0 on the next cycle.
REQ-040 SHALL cover FIFO fill: tx_ready=0, push 0x41..0x45 -> TXSTAT reads 0x6 (overflow=1, full=1); then tx_ready=1 -> tx_data sequence is 0x41,0x42,0x43,0x44, after which TXSTAT reads 0x5.
REQ-041 SHALL cover full push+pop: with the FIFO full and tx_ready=1, push 0x55 -> accepted, count stays 4, overflow stays 0, and 0x55 emerges last.
REQ-042 SHALL cover overflow clear: with overflow=1, write 0x4 to 0x8000_000C -> TXSTAT bit 2 reads 0.
REQ-043 SHALL cover reset mid-transfer: 3 entries queued with tx_ready=0, pulse reset for 1 cycle -> tx_valid=0, led=0, CYCLE=0, and RAM contents retained.

Source files
------------

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: byte-lane RAM plus CYCLE/LED/TX-FIFO MMIO registers behind one CPU data port
// Loads complete combinationally; all state commits on the rising edge.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   mem [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [31:0]   cycle_q, cycle_d;
    logic [7:0]    led_q, led_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ram_sel, cyc_sel, led_sel, txd_sel, txs_sel;
    logic          full, empty, push, pop, accept;
    logic [AW-1:0] widx;

    always_comb begin
        ram_sel  = daddr < 32'(4 * RAM_WORDS);
        widx     = daddr[AW+1:2];
        cyc_sel  = daddr[31:2] == 30'h2000_0000;
        led_sel  = daddr[31:2] == 30'h2000_0001;
        txd_sel  = daddr[31:2] == 30'h2000_0002;
        txs_sel  = daddr[31:2] == 30'h2000_0003;
        full     = count_q == FULL_CNT;
        empty    = count_q == '0;
        pop      = !empty && tx_ready && !reset;
        push     = txd_sel && dwe[0] && !reset;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        accept   = push && (!full || pop);
        cycle_d  = cycle_q + 32'd1;
        led_d    = (led_sel && dwe[0]) ? dwdata[7:0] : led_q;
        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + (PW+1)'(accept) - (PW+1)'(pop);
        ovf_d    = (push && !accept) || (ovf_q && !(txs_sel && dwe[0] && dwdata[2]));
        drdata   = ram_sel ? mem[widx] :
                   cyc_sel ? cycle_q :
                   led_sel ? {24'b0, led_q} :
                   txs_sel ? {29'b0, ovf_q, full, empty} : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            led_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            led_q    <= led_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset so they map onto memory macros.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_sel && !reset && dwe[i]) mem[widx][8*i +: 8] <= dwdata[8*i +: 8];
        if (accept) fifo[wr_ptr_q] <= dwdata[7:0];
    end

    assign led      = led_q;
    assign tx_valid = !empty;
    assign tx_data  = fifo[rd_ptr_q];
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed checks of RAM lanes, CYCLE, LED, TX FIFO and reset behaviour
module tb_data_mem_mmio;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;
    logic [7:0]  led, tx_data;
    logic        tx_valid, tx_ready;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc_exp = 32'd0;
    logic [7:0]  exp_seq [4];

    data_mem_mmio dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .drdata(drdata), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_exp = reset ? 32'd0 : cyc_exp + 32'd1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        daddr = a;
        dwdata = d;
        dwe = we;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_ready = 1'b0;
        drive(32'h0, 32'h0, 4'h0);
        tick();
        tick();
        reset = 1'b0;
        drive(32'h8000_0000, 32'h0, 4'h0);
        chk("cycle_reset", drdata, 32'd0);
        chk("led_reset", {24'b0, led}, 32'd0);
        chk("txvalid_reset", {31'b0, tx_valid}, 32'd0);
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("txstat_reset", drdata, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        drive(32'h8000_0000, 32'h0, 4'h0);
        chk("cycle_5", drdata, 32'd5);

        drive(32'h10, 32'h1122_3344, 4'hF);
        tick();
        drive(32'h10, 32'hAAAA_AAAA, 4'b0010);
        chk("ram_no_writethrough", drdata, 32'h1122_3344);
        tick();
        drive(32'h10, 32'h0, 4'h0);
        chk("ram_lane1", drdata, 32'h1122_AA44);
        drive(32'h14, 32'hDEAD_BEEF, 4'hF);
        tick();
        drive(32'h0, 32'h0BAD_F00D, 4'hF);
        tick();
        drive(32'hFFC, 32'hCAFE_0123, 4'hF);
        tick();
        drive(32'h1000, 32'hFFFF_FFFF, 4'hF);
        tick();
        drive(32'h1000, 32'h0, 4'h0);
        chk("unmapped_read", drdata, 32'h0);
        drive(32'h0, 32'h0, 4'h0);
        chk("ram_no_alias", drdata, 32'h0BAD_F00D);
        drive(32'hFFE, 32'h0, 4'h0);
        chk("ram_top_word", drdata, 32'hCAFE_0123);
        drive(32'h10, 32'h0, 4'h0);
        chk("ram_neighbour", drdata, 32'h1122_AA44);

        drive(32'h8000_0004, 32'h1234_56A5, 4'b0001);
        tick();
        drive(32'h8000_0004, 32'hFFFF_FFFF, 4'b1110);
        tick();
        drive(32'h8000_0007, 32'h0, 4'h0);
        chk("led_port", {24'b0, led}, 32'hA5);
        chk("led_read", drdata, 32'h0000_00A5);
        drive(32'h8000_0008, 32'h0, 4'h0);
        chk("txdata_read_zero", drdata, 32'h0);
        drive(32'h8000_0000, 32'h0, 4'hF);
        tick();
        drive(32'h8000_0000, 32'h0, 4'h0);
        chk("cycle_ignores_write", drdata, cyc_exp);

        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        chk("cycle_forced", drdata, 32'hFFFF_FFFF);
        release dut.cycle_q;
        tick();
        chk("cycle_wrap", drdata, 32'h0);
        cyc_exp = 32'd0;

        for (int i = 0; i < 4; i++) begin
            drive(32'h8000_0008, {4{8'h41 + 8'(i)}}, 4'b0001);
            tick();
        end
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("txstat_full", drdata, 32'h2);
        drive(32'h8000_0008, 32'h4545_4545, 4'b0001);
        tick();
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("txstat_overflow", drdata, 32'h6);
        chk("tx_head_stable", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tx_drain", {24'b0, tx_data}, 32'h41 + i);
            tick();
        end
        chk("txvalid_drained", {31'b0, tx_valid}, 32'd0);
        chk("txstat_ovf_empty", drdata, 32'h5);
        drive(32'h8000_000C, 32'h4, 4'b0001);
        tick();
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("ovf_clear", drdata, 32'h1);

        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h8000_0008, 32'h61 + i, 4'b0001);
            tick();
        end
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("txstat_full2", drdata, 32'h2);
        tx_ready = 1'b1;
        drive(32'h8000_0008, 32'h55, 4'b0001);
        tick();
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("full_pushpop_stat", drdata, 32'h2);
        exp_seq[0] = 8'h62;
        exp_seq[1] = 8'h63;
        exp_seq[2] = 8'h64;
        exp_seq[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pushpop_order", {24'b0, tx_data}, {24'b0, exp_seq[i]});
            tick();
        end
        chk("pushpop_empty", drdata, 32'h1);

        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h8000_0008, 32'h71 + i, 4'b0001);
            tick();
        end
        drive(32'h0, 32'h0, 4'h0);
        chk("queued_valid", {31'b0, tx_valid}, 32'd1);
        reset = 1'b1;
        drive(32'h8000_0004, 32'h77, 4'b0001);
        tick();
        reset = 1'b0;
        drive(32'h8000_0000, 32'h0, 4'h0);
        chk("rst_cycle", drdata, 32'h0);
        chk("rst_txvalid", {31'b0, tx_valid}, 32'd0);
        chk("rst_led", {24'b0, led}, 32'h0);
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("rst_txstat", drdata, 32'h1);
        drive(32'h10, 32'h0, 4'h0);
        chk("rst_ram_kept", drdata, 32'h1122_AA44);
        drive(32'h14, 32'h0, 4'h0);
        chk("rst_ram_kept2", drdata, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
